branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage RV64 pipeline.
- Replaces static predict-not-taken with early redirection:
  - IF looks up the current PC and gets a predicted next PC in the same cycle.
  - The branch-resolution stage (EX/MEM) sends the actual outcome back to train the tables.
- Contains a direct-mapped BTB, a 2-bit saturating-counter pattern table, an optional global history register (gshare mode) and two performance counters.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB, 2-bit counter PHT with optional
// gshare history, combinational lookup from registered state.
module branch_predictor #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned GHR_W   = 0,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [XLEN-1:0]            if_pc,
  output logic                       pred_taken,
  output logic [XLEN-1:0]            pred_next_pc,
  output logic [$clog2(ENTRIES)-1:0] pred_pht_idx,
  input  logic                       upd_valid,
  input  logic [XLEN-1:0]            upd_pc,
  input  logic [$clog2(ENTRIES)-1:0] upd_pht_idx,
  input  logic                       upd_is_jump,
  input  logic                       upd_taken,
  input  logic [XLEN-1:0]            upd_target,
  input  logic                       upd_mispredict,
  output logic [CNT_W-1:0]           branch_count,
  output logic [CNT_W-1:0]           mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam int unsigned HW    = (GHR_W > 0) ? GHR_W : 1;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         pht_q    [ENTRIES];
  logic [HW-1:0]      ghr_q;
  logic [CNT_W-1:0]   branch_cnt_q;
  logic [CNT_W-1:0]   mis_cnt_q;

  logic [IDX_W-1:0] bidx;
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] ubidx;
  logic [TAG_W-1:0] ltag;
  logic [TAG_W-1:0] utag;
  logic             hit;
  logic             unused_bits;

  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

  always_comb begin
    bidx  = if_pc[IDX_W+1:2];
    ltag  = if_pc[XLEN-1:IDX_W+2];
    ubidx = upd_pc[IDX_W+1:2];
    utag  = upd_pc[XLEN-1:IDX_W+2];
    pidx  = (GHR_W > 0) ? (bidx ^ IDX_W'(ghr_q)) : bidx;
    hit   = valid_q[bidx] && (tag_q[bidx] == ltag);
  end

  // Gated by rst so the prediction is already quiet in the cycle reset is applied.
  always_comb begin
    pred_taken   = rst && hit && (jump_q[bidx] || pht_q[pidx][1]);
    pred_next_pc = pred_taken ? target_q[bidx] : (if_pc + XLEN'(4));
    pred_pht_idx = pidx;
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mis_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      jump_q       <= '0;
      ghr_q        <= '0;
      branch_cnt_q <= '0;
      mis_cnt_q    <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (!upd_is_jump) begin
        if (upd_taken && (pht_q[upd_pht_idx] != 2'b11)) begin
          pht_q[upd_pht_idx] <= pht_q[upd_pht_idx] + 2'd1;
        end else if (!upd_taken && (pht_q[upd_pht_idx] != 2'b00)) begin
          pht_q[upd_pht_idx] <= pht_q[upd_pht_idx] - 2'd1;
        end
        if (branch_cnt_q != '1) begin
          branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        end
        if (GHR_W > 0) begin
          ghr_q <= HW'({ghr_q, upd_taken});
        end
      end
      if (upd_is_jump) begin
        jump_q[ubidx] <= 1'b1;
      end else if (upd_taken) begin
        jump_q[ubidx] <= 1'b0;
      end
      if (upd_taken) begin
        valid_q[ubidx] <= 1'b1;
      end
      if (upd_mispredict && (mis_cnt_q != '1)) begin
        mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && upd_valid && upd_taken) begin
      tag_q[ubidx]    <= utag;
      target_q[ubidx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance (4-bit counters) and a gshare instance share
// stimulus; expectations are queued when driven and compared when sampled.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] if_pc, upd_pc, upd_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_mispredict;
  logic [5:0]  upd_idx_a, upd_idx_b;

  logic        a_taken, b_taken;
  logic [63:0] a_next, b_next;
  logic [5:0]  a_idx, b_idx;
  logic [3:0]  a_bc, a_mc;
  logic [31:0] b_bc, b_mc;

  branch_predictor #(.XLEN(64), .ENTRIES(64), .GHR_W(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(a_taken), .pred_next_pc(a_next), .pred_pht_idx(a_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_idx(upd_idx_a),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
    .branch_count(a_bc), .mispredict_count(a_mc)
  );

  branch_predictor #(.XLEN(64), .ENTRIES(64), .GHR_W(4), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(b_taken), .pred_next_pc(b_next), .pred_pht_idx(b_idx),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_pht_idx(upd_idx_b),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
    .branch_count(b_bc), .mispredict_count(b_mc)
  );

  string       tq[$];
  logic [63:0] vq[$];
  int compared   = 0;
  int mismatched = 0;
  int a_wrong    = 0;

  task automatic push(input string tag, input logic [63:0] val);
    tq.push_back(tag);
    vq.push_back(val);
  endtask

  task automatic pop_cmp(input logic [63:0] obs);
    string       tag;
    logic [63:0] exp;
    tag = tq.pop_front();
    exp = vq.pop_front();
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [63:0] pc,
                      input logic exp_t, input logic [63:0] exp_n);
    if_pc = pc;
    push({tag, "_taken"}, 64'(exp_t));
    push({tag, "_next"}, exp_n);
    #1;
    pop_cmp(64'(a_taken));
    pop_cmp(a_next);
  endtask

  task automatic cnt(input string tag, input logic [3:0] eb, input logic [3:0] em);
    push({tag, "_bcnt"}, 64'(eb));
    push({tag, "_mcnt"}, 64'(em));
    #1;
    pop_cmp(64'(a_bc));
    pop_cmp(64'(a_mc));
  endtask

  task automatic upd(input logic [63:0] pc, input logic jmp, input logic tk,
                     input logic [63:0] tgt, input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_idx_a      = pc[7:2];
    upd_idx_b      = pc[7:2];
    upd_is_jump    = jmp;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic do_reset(input logic with_upd);
    rst = 1'b0;
    if (with_upd) begin
      upd_valid      = 1'b1;
      upd_pc         = 64'h100;
      upd_idx_a      = '0;
      upd_idx_b      = '0;
      upd_is_jump    = 1'b0;
      upd_taken      = 1'b1;
      upd_target     = 64'h900;
      upd_mispredict = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst       = 1'b1;
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_is_jump = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    upd_idx_a = '0; upd_idx_b = '0;

    // reset state
    do_reset(1'b0);
    look("rst", 64'h100, 1'b0, 64'h104);
    cnt("rst", 4'd0, 4'd0);
    push("rst_idx_a", 64'd0); push("rst_idx_b", 64'd0);
    pop_cmp(64'(a_idx)); pop_cmp(64'(b_idx));
    do_reset(1'b1);
    look("rst_upd", 64'h100, 1'b0, 64'h104);
    cnt("rst_upd", 4'd0, 4'd0);

    // bimodal counter training and saturation
    upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b0);
    upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b0);
    look("bim_tt", 64'h200, 1'b1, 64'h180);
    upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b0);
    look("bim_ttn", 64'h200, 1'b1, 64'h180);
    upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b0);
    look("bim_ttnn", 64'h200, 1'b0, 64'h204);
    repeat (5) upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b0);
    cnt("bim_nine", 4'd9, 4'd0);
    repeat (2) upd(64'h200, 1'b0, 1'b0, 64'h0, 1'b0);
    upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b0);
    look("bim_floor", 64'h200, 1'b0, 64'h204);
    upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b0);
    look("bim_floor2", 64'h200, 1'b1, 64'h180);
    cnt("bim_cnt", 4'd13, 4'd0);

    // reset mid-operation clears the trained entry
    do_reset(1'b0);
    look("rst_mid", 64'h200, 1'b0, 64'h204);
    cnt("rst_mid", 4'd0, 4'd0);

    // aliasing entries share bidx 0
    upd(64'h200, 1'b0, 1'b1, 64'h180, 1'b0);
    upd(64'h300, 1'b0, 1'b1, 64'h380, 1'b0);
    look("alias_old", 64'h200, 1'b0, 64'h204);
    look("alias_new", 64'h300, 1'b1, 64'h380);

    // JAL: predicted regardless of PHT, PHT and branch_count untouched
    do_reset(1'b0);
    upd(64'h400, 1'b1, 1'b1, 64'h800, 1'b0);
    look("jal", 64'h400, 1'b1, 64'h800);
    cnt("jal", 4'd0, 4'd0);
    upd(64'h1400, 1'b0, 1'b1, 64'h1800, 1'b0);
    look("jal_pht_t", 64'h1400, 1'b1, 64'h1800);
    upd(64'h1400, 1'b0, 1'b0, 64'h0, 1'b0);
    look("jal_pht_n", 64'h1400, 1'b0, 64'h1404);
    cnt("jal_after", 4'd2, 4'd0);

    // same-cycle lookup and update: no bypass
    do_reset(1'b0);
    if_pc = 64'h200;
    upd_valid = 1'b1; upd_pc = 64'h200; upd_idx_a = '0; upd_idx_b = '0;
    upd_is_jump = 1'b0; upd_taken = 1'b1; upd_target = 64'h180; upd_mispredict = 1'b0;
    push("same_old_taken", 64'd0);
    push("same_old_next", 64'h204);
    #1;
    pop_cmp(64'(a_taken));
    pop_cmp(a_next);
    @(negedge clk);
    upd_valid = 1'b0;
    look("same_new", 64'h200, 1'b1, 64'h180);

    // mispredict counter saturation (4-bit)
    do_reset(1'b0);
    upd(64'h600, 1'b1, 1'b0, 64'h0, 1'b1);
    cnt("mis1", 4'd0, 4'd1);
    repeat (14) upd(64'h600, 1'b1, 1'b0, 64'h0, 1'b1);
    cnt("mis15", 4'd0, 4'd15);
    upd(64'h600, 1'b1, 1'b0, 64'h0, 1'b1);
    cnt("mis_sat", 4'd0, 4'd15);

    // alternating branch: gshare learns it, bimodal cannot
    do_reset(1'b0);
    for (int k = 0; k < 24; k++) begin
      logic o;
      o = (k % 2 == 0);
      if_pc = 64'h500;
      #1;
      if (k >= 16) begin
        push("gs_taken", 64'(o));
        push("gs_next", o ? 64'h600 : 64'h504);
        pop_cmp(64'(b_taken));
        pop_cmp(b_next);
        if (a_taken !== o) a_wrong++;
      end
      upd_valid = 1'b1; upd_pc = 64'h500; upd_idx_a = a_idx; upd_idx_b = b_idx;
      upd_is_jump = 1'b0; upd_taken = o; upd_target = 64'h600; upd_mispredict = 1'b0;
      @(negedge clk);
      upd_valid = 1'b0;
    end
    push("bim_alt_wrong_ge4", 64'd1);
    pop_cmp(64'(a_wrong >= 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
